cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have one clock and reset as decided: clk input 1, rising-edge clock. rst input 1, asynchronous active-low reset.
REQ-002 SHALL provide reqN_rd (N=0,1) input 1: requester N memory read.
REQ-003 SHALL provide reqN_wr input 1: requester N memory write.
REQ-004 SHALL provide reqN_lock input 1: requester N holds ownership across a multi-word line burst.
REQ-005 SHALL provide reqN_addr input 16: word address.
REQ-006 SHALL provide reqN_data input 16: write data.
REQ-007 SHALL provide gntN output 1: requester N owns the memory.
REQ-008 SHALL provide busyN output 4: per-bank busy seen by requester N.
REQ-009 SHALL provide rvalidN output 1: rdata belongs to requester N this cycle.
REQ-010 SHALL provide errN output 1: error for requester N.
REQ-011 SHALL provide rdata output 16: read data return, shared by both requesters.
REQ-012 SHALL provide fm_addr output 16, fm_data_in output 16, fm_rd output 1 and fm_wr output 1 to the four-bank memory.
REQ-013 SHALL provide m_data_out input 16, m_busy input 4 and m_err input 1 from the four-bank memory.

Function
REQ-014 SHALL implement FSM IDLE, OWN0 and OWN1; gnt0=(state==OWN0) and gnt1=(state==OWN1), decoded from registered state only.
REQ-015 Requester N is active when reqN_rd|reqN_wr|reqN_lock.
REQ-016 From IDLE, one active requester SHALL move to its OWN state on the next edge; both active SHALL select the requester not last granted (rr bit); rr toggles on every grant.
REQ-017 In OWNn, the owner is idle when its lock, rd and wr are all 0; then, if the other requester is active, SHALL hand off directly to OWN(other) on the same edge, else go to IDLE.
REQ-018 An owner asserting lock SHALL never lose the grant (no preemption).
REQ-019 An access is accepted when gnt & (rd^wr) & ~m_busy[addr[2:1]].
REQ-020 Accepted accesses SHALL drive fm_addr, fm_data_in, fm_rd and fm_wr from the owner; otherwise all fm_* = 0. There is no combinational path from the non-owner to fm_*.
REQ-021 Owner busyN = m_busy; non-owner busyN = 4'b1111.
REQ-022 Read data latency is fixed at 2 cycles after acceptance.
REQ-023 A 2-stage return-tag pipe {valid, id} SHALL be pushed on each accepted read and shifted every cycle.
REQ-024 When stage 2 is valid, rvalid[id]=1 and rdata=m_data_out; otherwise rvalid=0 and rdata=0.
REQ-025 Return routing SHALL be correct across grant hand-offs: a read issued by requester 0 the cycle before a hand-off still returns on rvalid0.
REQ-026 Owner with rd&wr both 1 SHALL get errN=1 that cycle, with no memory access.
REQ-027 m_err SHALL be routed to the owner's errN. A non-owner's err is 0 except per REQ-026, which applies to the owner only.
REQ-028 Up to 2 reads SHALL be outstanding simultaneously, allowing back-to-back reads to different banks.

Reset
REQ-029 On rst=0, SHALL asynchronously force state=IDLE, rr=0 (requester 0 wins first tie) and tag pipe cleared.
REQ-030 While rst=0, all outputs SHALL be 0: gnt, rvalid, err, rdata and fm_*; busyN SHALL be 4'b1111 because no owner exists.
REQ-031 Reset mid-burst SHALL drop in-flight returns; no rvalid is produced for them after release.

Structure
REQ-032 A shared package SHALL hold state encodings (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10), READ_LAT=2 and requester-id width.
REQ-033 The tag pipe SHALL be one sub-module, arb_return_tag_pipe, built with depth READ_LAT.

Verification
REQ-034 Reset then req0_rd=1, addr=16'h0010, data at 2 cycles=16'hBEEF -> gnt0 next cycle, fm_rd=1 with fm_addr=16'h0010, rvalid0=1 with rdata=16'hBEEF two cycles later, rvalid1=0.
REQ-035 req0 and req1 raised the same cycle after reset -> OWN0 granted; after req0 goes idle, direct hand-off to OWN1 with no IDLE cycle; next tie -> requester 1 is not preferred again.
REQ-036 req0_lock=1 for 4-word fill, req1_wr waiting -> busy1=4'b1111 and fm_wr=0 throughout the burst; gnt1 only after lock0=0.
REQ-037 Owner req0 reads bank 3 then idles the next cycle; req1 gets the grant -> rvalid0 still fires 2 cycles after issue, never rvalid1.
REQ-038 Owner asserts rd=wr=1 -> errN=1, fm_rd=fm_wr=0. m_busy[1]=1 with owner addr[2:1]=1 -> no fm_rd until the bank clears.
REQ-039 rst=0 mid-burst with a read in flight -> outputs zero immediately, no rvalid after release, first grant goes to requester 0.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the two-requester cache memory arbiter.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    localparam int READ_LAT = 2;
    localparam int ID_W     = 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } ret_tag_t;

endpackage

// File: rtl/arb_return_tag_pipe.sv
// Read-return tag shift pipe: remembers which requester issued each read so
// the data coming back DEPTH cycles later is routed to the right rvalid.
module arb_return_tag_pipe
    import cache_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = READ_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_push_id,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    ret_tag_t r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: i_push, id: i_push_id};
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[DEPTH-1].valid;
    assign o_id    = r_pipe[DEPTH-1].id;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-requester arbiter in front of a four-bank memory with lockable bursts,
// round-robin tie break and tagged fixed-latency read return.
//
// state   | meaning
// IDLE    | no owner, memory interface quiet
// OWN0    | requester 0 owns the memory
// OWN1    | requester 1 owns the memory
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_rd,
    input  logic        req0_wr,
    input  logic        req0_lock,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req0_data,
    input  logic        req1_rd,
    input  logic        req1_wr,
    input  logic        req1_lock,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req1_data,
    output logic        gnt0,
    output logic        gnt1,
    output logic [3:0]  busy0,
    output logic [3:0]  busy1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rdata,
    output logic [15:0] fm_addr,
    output logic [15:0] fm_data_in,
    output logic        fm_rd,
    output logic        fm_wr,
    input  logic [15:0] m_data_out,
    input  logic [3:0]  m_busy,
    input  logic        m_err
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_rr;

    logic        w_act0;
    logic        w_act1;
    logic        w_own_rd;
    logic        w_own_wr;
    logic [15:0] w_own_addr;
    logic [15:0] w_own_data;
    logic        w_accept;
    logic        w_push;
    logic [ID_W-1:0] w_push_id;
    logic        w_ret_valid;
    logic [ID_W-1:0] w_ret_id;

    assign w_act0 = req0_rd | req0_wr | req0_lock;
    assign w_act1 = req1_rd | req1_wr | req1_lock;

    // r_rr holds the requester preferred on the next tie (the one not last granted).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE)) begin
                r_rr <= (w_state_nxt == ST_OWN0);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_act0 && w_act1) begin
                    w_state_nxt = r_rr ? ST_OWN1 : ST_OWN0;
                end else if (w_act0) begin
                    w_state_nxt = ST_OWN0;
                end else if (w_act1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!w_act0) begin
                    w_state_nxt = w_act1 ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!w_act1) begin
                    w_state_nxt = w_act0 ? ST_OWN0 : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Only the owner's request reaches the memory; the non-owner is fully masked.
    always_comb begin
        gnt0       = (r_state == ST_OWN0);
        gnt1       = (r_state == ST_OWN1);
        w_own_rd   = 1'b0;
        w_own_wr   = 1'b0;
        w_own_addr = '0;
        w_own_data = '0;
        if (gnt0) begin
            w_own_rd   = req0_rd;
            w_own_wr   = req0_wr;
            w_own_addr = req0_addr;
            w_own_data = req0_data;
        end else if (gnt1) begin
            w_own_rd   = req1_rd;
            w_own_wr   = req1_wr;
            w_own_addr = req1_addr;
            w_own_data = req1_data;
        end
        w_accept   = (gnt0 | gnt1) & (w_own_rd ^ w_own_wr) & ~m_busy[w_own_addr[2:1]];
        fm_addr    = w_accept ? w_own_addr : '0;
        fm_data_in = w_accept ? w_own_data : '0;
        fm_rd      = w_accept & w_own_rd;
        fm_wr      = w_accept & w_own_wr;
        busy0      = gnt0 ? m_busy : 4'b1111;
        busy1      = gnt1 ? m_busy : 4'b1111;
        err0       = gnt0 & ((req0_rd & req0_wr) | m_err);
        err1       = gnt1 & ((req1_rd & req1_wr) | m_err);
        w_push     = w_accept & w_own_rd;
        w_push_id  = gnt1 ? 1'b1 : 1'b0;
    end

    arb_return_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_push_id (w_push_id),
        .o_valid   (w_ret_valid),
        .o_id      (w_ret_id)
    );

    assign rvalid0 = w_ret_valid & (w_ret_id == 1'b0);
    assign rvalid1 = w_ret_valid & (w_ret_id == 1'b1);
    assign rdata   = w_ret_valid ? m_data_out : '0;

endmodule
